// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of each complete cycle of an
// asynchronous PWM line, in clk cycles, and flags a stuck line with a timeout.
//
// Ports:
//   clk        clock, all flops update on the rising edge
//   rst        synchronous reset, active-high
//   enable     1 = measure, 0 = idle with results held
//   pwm_in     asynchronous PWM input
//   period     clks between consecutive rising edges (0 on timeout)
//   high_time  clks from a rising edge to the following falling edge
//   valid      one-clk strobe when period/high_time/timeout are updated
//   timeout    set with valid when the counter saturated without an edge

module pwm_capture #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    // A single-flop synchroniser is never safe, so anything below 2 is raised.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [STAGES-1:0] sync_q;
    logic              s;
    logic              s_prev;
    logic              rise;
    logic              fall;

    logic [WIDTH-1:0]  cnt;
    logic              cnt_sat;
    logic [WIDTH-1:0]  hl;

    logic              emit;
    logic              emit_to;
    logic              hl_load;
    logic [WIDTH-1:0]  res_period;
    logic [WIDTH-1:0]  res_high;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection. Both edges see the same
    // latency, so the measured widths are exact.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pwm_in};
            s_prev <= sync_q[STAGES-1];
        end
    end

    assign s    = sync_q[STAGES-1];
    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

    // ------------------------------------------------------------------
    // Free-running saturating counter. It restarts at 1 on each rise so
    // that its value on the next rise equals the period.
    // ------------------------------------------------------------------
    assign cnt_sat = (cnt == MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= ONE;
        end else if (!cnt_sat) begin
            cnt <= cnt + ONE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Dropping enable wins over every event, so a
    // partial measurement is simply abandoned. An edge wins over
    // saturation, which keeps period=MAX a legal result.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: state_next = ARM;
                ARM: begin
                    if (rise) begin
                        state_next = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_next = LOW;
                    end else if (cnt_sat) begin
                        state_next = ARM;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_next = HIGH;
                    end else if (cnt_sat) begin
                        state_next = ARM;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Produces the result to be registered this clk, if any.
    // ARM never times out, so a stuck line reports exactly once.
    // ------------------------------------------------------------------
    always_comb begin
        emit       = 1'b0;
        emit_to    = 1'b0;
        hl_load    = 1'b0;
        res_period = '0;
        res_high   = '0;
        if (enable) begin
            unique case (state)
                HIGH: begin
                    if (fall) begin
                        hl_load = 1'b1;
                    end else if (cnt_sat) begin
                        emit     = 1'b1;
                        emit_to  = 1'b1;
                        res_high = MAX;
                    end
                end
                LOW: begin
                    if (rise) begin
                        emit       = 1'b1;
                        res_period = cnt;
                        res_high   = hl;
                    end else if (cnt_sat) begin
                        emit    = 1'b1;
                        emit_to = 1'b1;
                    end
                end
                default: begin
                    emit = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // High-time latch and registered result outputs. Results change only
    // together with valid and hold otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hl <= '0;
        end else if (hl_load) begin
            hl <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= emit;
            if (emit) begin
                period    <= res_period;
                high_time <= res_high;
                timeout   <= emit_to;
            end
        end
    end

endmodule
